dfr_reservoir_sequencer: RTL and testbench

Drives the time-multiplexed reservoir for the DFR core. It fetches input samples from sample memory, applies a per-virtual-node sign mask, and hands each masked value to the reservoir node via a req/ack handshake. When enabled, it writes node outputs into reservoir history memory.
- Produces the reservoir_init_busy, reservoir_busy and reservoir_filled status consumed by the core controller.
- Consumes the controller's reservoir_en, reservoir_rst, reservoir_history_en and sample_cntr_rst.

---
 rtl/dfr_reservoir_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_dfr_reservoir_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfr_reservoir_sequencer.sv
`default_nettype none
// dfr_reservoir_sequencer: fetches samples, applies the per-node sign mask and feeds the reservoir node.
// Rev 1.0
module dfr_reservoir_sequencer #(
  parameter int                       ADDR_WIDTH    = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       VIRTUAL_NODES = 10,
  parameter int                       INIT_SAMPLES  = 10,
  parameter int                       NUM_SAMPLES   = 100,
  parameter logic [VIRTUAL_NODES-1:0] MASK          = {VIRTUAL_NODES{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reservoir_rst,
  input  logic                  reservoir_en,
  input  logic                  reservoir_history_en,
  input  logic                  sample_cntr_rst,
  output logic                  sample_rd_en,
  output logic [ADDR_WIDTH-1:0] sample_addr,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  node_req,
  output logic [DATA_WIDTH-1:0] node_data_in,
  input  logic                  node_ack,
  input  logic [DATA_WIDTH-1:0] node_data_out,
  output logic                  history_wr_en,
  output logic [ADDR_WIDTH-1:0] history_addr,
  output logic [DATA_WIDTH-1:0] history_data,
  output logic                  reservoir_init_busy,
  output logic                  reservoir_busy,
  output logic                  reservoir_filled
);

  localparam int                    NODE_W    = $clog2(VIRTUAL_NODES);
  localparam logic [NODE_W-1:0]     LAST_NODE = NODE_W'(VIRTUAL_NODES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_INIT = ADDR_WIDTH'(INIT_SAMPLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_RUN  = ADDR_WIDTH'(NUM_SAMPLES - 1);
  localparam logic [ADDR_WIDTH-1:0] RUN_BASE  = ADDR_WIDTH'(INIT_SAMPLES);
  localparam logic [ADDR_WIDTH-1:0] NODES_A   = ADDR_WIDTH'(VIRTUAL_NODES);
  localparam logic [DATA_WIDTH-1:0] DATA_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_REQ   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] sample_idx_q, sample_idx_d;
  logic [NODE_W-1:0]     node_idx_q, node_idx_d;
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  sample_valid_q;
  logic                  init_done_q, run_done_q, hold_q, filled_q;
  logic                  sample_rd_en_q, node_req_q, history_wr_en_q;
  logic [ADDR_WIDTH-1:0] sample_addr_q, history_addr_q;
  logic [DATA_WIDTH-1:0] node_data_in_q, history_data_q;

  logic                  node_last, sample_last, phase_done, resume_ok;
  logic [ADDR_WIDTH-1:0] cur_fetch_addr, next_fetch_addr, hist_addr_d;

  // Negating the most negative value saturates to the most positive one.
  function automatic logic [DATA_WIDTH-1:0] apply_mask(input logic [DATA_WIDTH-1:0] s,
                                                       input logic                  pass);
    if (pass) return s;
    if (s == DATA_MIN) return ~s;
    return -s;
  endfunction

  always_comb begin
    node_last       = (node_idx_q == LAST_NODE);
    node_idx_d      = node_last ? '0 : node_idx_q + NODE_W'(1);
    sample_idx_d    = sample_idx_q + ADDR_WIDTH'(1);
    sample_last     = init_done_q ? (sample_idx_q == LAST_RUN) : (sample_idx_q == LAST_INIT);
    phase_done      = hold_q | run_done_q;
    resume_ok       = (node_idx_q != '0) && sample_valid_q;
    cur_fetch_addr  = init_done_q ? RUN_BASE + sample_idx_q : sample_idx_q;
    next_fetch_addr = init_done_q ? RUN_BASE + sample_idx_d : sample_idx_d;
    hist_addr_d     = (sample_idx_q - ADDR_WIDTH'(1)) * NODES_A + ADDR_WIDTH'(node_idx_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      sample_idx_q    <= '0;
      node_idx_q      <= '0;
      sample_q        <= '0;
      sample_valid_q  <= 1'b0;
      init_done_q     <= 1'b0;
      run_done_q      <= 1'b0;
      hold_q          <= 1'b0;
      filled_q        <= 1'b0;
      sample_rd_en_q  <= 1'b0;
      sample_addr_q   <= '0;
      node_req_q      <= 1'b0;
      node_data_in_q  <= '0;
      history_wr_en_q <= 1'b0;
      history_addr_q  <= '0;
      history_data_q  <= '0;
    end else if (reservoir_rst || sample_cntr_rst) begin
      // A counter clear keeps the phase flags so the run phase can follow washout.
      state_q         <= S_IDLE;
      sample_idx_q    <= '0;
      node_idx_q      <= '0;
      sample_q        <= '0;
      sample_valid_q  <= 1'b0;
      hold_q          <= 1'b0;
      filled_q        <= 1'b0;
      sample_rd_en_q  <= 1'b0;
      sample_addr_q   <= '0;
      node_req_q      <= 1'b0;
      node_data_in_q  <= '0;
      history_wr_en_q <= 1'b0;
      history_addr_q  <= '0;
      history_data_q  <= '0;
      if (reservoir_rst) begin
        init_done_q <= 1'b0;
        run_done_q  <= 1'b0;
      end
    end else begin
      sample_rd_en_q  <= 1'b0;
      history_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (reservoir_en && !phase_done) begin
            if (resume_ok) begin
              state_q        <= S_REQ;
              node_req_q     <= 1'b1;
              node_data_in_q <= apply_mask(sample_q, MASK[node_idx_q]);
            end else begin
              state_q        <= S_FETCH;
              sample_rd_en_q <= 1'b1;
              sample_addr_q  <= cur_fetch_addr;
            end
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          sample_q       <= sample_data;
          sample_valid_q <= 1'b1;
          node_req_q     <= 1'b1;
          node_data_in_q <= apply_mask(sample_data, MASK[node_idx_q]);
          state_q        <= S_REQ;
        end
        S_REQ: begin
          if (node_ack) begin
            node_req_q      <= 1'b0;
            history_data_q  <= node_data_out;
            history_addr_q  <= hist_addr_d;
            history_wr_en_q <= reservoir_history_en & filled_q;
            state_q         <= S_WRITE;
          end
        end
        S_WRITE: begin
          node_idx_q <= node_idx_d;
          if (node_last) begin
            sample_idx_q   <= sample_idx_d;
            sample_valid_q <= 1'b0;
            if (init_done_q && sample_idx_q == '0) filled_q <= 1'b1;
            if (sample_last) begin
              if (init_done_q) begin
                run_done_q <= 1'b1;
              end else begin
                init_done_q <= 1'b1;
                hold_q      <= 1'b1;
              end
            end
          end
          if (!reservoir_en || (node_last && sample_last)) begin
            state_q <= S_IDLE;
          end else if (node_last) begin
            state_q        <= S_FETCH;
            sample_rd_en_q <= 1'b1;
            sample_addr_q  <= next_fetch_addr;
          end else begin
            state_q        <= S_REQ;
            node_req_q     <= 1'b1;
            node_data_in_q <= apply_mask(sample_q, MASK[node_idx_d]);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_rd_en        = sample_rd_en_q;
  assign sample_addr         = sample_addr_q;
  assign node_req            = node_req_q;
  assign node_data_in        = node_data_in_q;
  assign history_wr_en       = history_wr_en_q;
  assign history_addr        = history_addr_q;
  assign history_data        = history_data_q;
  assign reservoir_init_busy = ~init_done_q;
  assign reservoir_busy      = ~run_done_q;
  assign reservoir_filled    = filled_q;

endmodule
`default_nettype wire

// File: tb/tb_dfr_reservoir_sequencer.sv
`default_nettype none
// tb_dfr_reservoir_sequencer: directed stimulus with queue-based scoreboard for the reservoir sequencer.
// Rev 1.0
module tb_dfr_reservoir_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reservoir_rst = 1'b0;
  logic        reservoir_en = 1'b0;
  logic        reservoir_history_en = 1'b0;
  logic        sample_cntr_rst = 1'b0;
  logic        sample_rd_en;
  logic [31:0] sample_addr;
  logic [31:0] sample_data = 32'h0;
  logic        node_req;
  logic [31:0] node_data_in;
  logic        node_ack = 1'b0;
  logic [31:0] node_data_out = 32'h0;
  logic        history_wr_en;
  logic [31:0] history_addr;
  logic [31:0] history_data;
  logic        reservoir_init_busy;
  logic        reservoir_busy;
  logic        reservoir_filled;

  always #5 clk = ~clk;

  dfr_reservoir_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .VIRTUAL_NODES(4),
    .INIT_SAMPLES(2), .NUM_SAMPLES(3), .MASK(4'b0101)
  ) dut (
    .clk(clk), .rst(rst), .reservoir_rst(reservoir_rst), .reservoir_en(reservoir_en),
    .reservoir_history_en(reservoir_history_en), .sample_cntr_rst(sample_cntr_rst),
    .sample_rd_en(sample_rd_en), .sample_addr(sample_addr), .sample_data(sample_data),
    .node_req(node_req), .node_data_in(node_data_in), .node_ack(node_ack),
    .node_data_out(node_data_out), .history_wr_en(history_wr_en), .history_addr(history_addr),
    .history_data(history_data), .reservoir_init_busy(reservoir_init_busy),
    .reservoir_busy(reservoir_busy), .reservoir_filled(reservoir_filled)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_q[$], req_q[$], hwa_q[$], hwd_q[$];
  int          rd_t[$], req_t[$];
  int          cyc = 0, rd_count = 0, hist_count = 0, ack_count = 0;
  int          ack_delay = 0, req_cnt = 0, cond_target = 0;
  bit          sat_mode = 1'b0, rd_pending = 1'b0;
  logic [31:0] rd_addr_l = 32'h0, held = 32'h0;
  logic        prev_req = 1'b0, prev_rd = 1'b0, prev_hw = 1'b0;

  int wash_exp[8]  = '{10, -10, 10, -10, 11, -11, 11, -11};
  int run_exp[12]  = '{12, -12, 12, -12, 13, -13, 13, -13, 14, -14, 14, -14};
  int hist_exp[8]  = '{13, -13, 13, -13, 14, -14, 14, -14};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected output %0h, required none", name, val);
  endtask

  // Sample memory: word k = 10+k; data is only meaningful in the cycle after the read strobe.
  always @(negedge clk) begin
    if (rd_pending) sample_data = (sat_mode && rd_addr_l == 32'd0) ? 32'h8000_0000 : 32'd10 + rd_addr_l;
    else            sample_data = 32'hDEAD_BEEF;
    rd_pending = rst && sample_rd_en;
    rd_addr_l  = sample_addr;
  end

  // Reservoir node: echoes its input, acking after ack_delay cycles of req.
  always @(negedge clk) begin
    if (node_req) begin
      if (req_cnt == ack_delay) begin
        node_ack      = 1'b1;
        node_data_out = node_data_in;
      end else begin
        node_ack      = 1'b0;
        node_data_out = 32'h5A5A_5A5A;
      end
      req_cnt++;
    end else begin
      node_ack      = 1'b0;
      node_data_out = 32'h5A5A_5A5A;
      req_cnt       = 0;
    end
  end

  always @(posedge clk)
    if (rst && !reservoir_rst && !sample_cntr_rst && node_req && node_ack) ack_count++;

  // Monitor: pops the scoreboard whenever the DUT presents a read, a request or a history write.
  always @(negedge clk) begin
    cyc++;
    if (rst && sample_rd_en) begin
      chk("rd_single_cycle", {31'd0, prev_rd}, 32'd0);
      rd_t.push_back(cyc);
      rd_count++;
      if (rd_q.size() == 0) unexpected("rd_addr", sample_addr);
      else chk("rd_addr", sample_addr, rd_q.pop_front());
    end
    if (rst && node_req) begin
      if (!prev_req) begin
        req_t.push_back(cyc);
        held = node_data_in;
        if (req_q.size() == 0) unexpected("req_data", node_data_in);
        else chk("req_data", node_data_in, req_q.pop_front());
      end else begin
        chk("req_stable", node_data_in, held);
      end
    end
    if (rst && history_wr_en) begin
      chk("hist_single_cycle", {31'd0, prev_hw}, 32'd0);
      hist_count++;
      if (hwa_q.size() == 0) unexpected("hist_addr", history_addr);
      else begin
        chk("hist_addr", history_addr, hwa_q.pop_front());
        chk("hist_data", history_data, hwd_q.pop_front());
      end
    end
    prev_req = node_req;
    prev_rd  = sample_rd_en;
    prev_hw  = history_wr_en;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return reservoir_init_busy == 1'b0;
      1:       return reservoir_busy == 1'b0;
      2:       return reservoir_filled == 1'b1;
      default: return node_req && (ack_count == cond_target);
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (cond(which)) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: condition not reached within %0d cycles", name, bound);
    end
  endtask

  task automatic push_wash();
    rd_q.push_back(32'd0);
    rd_q.push_back(32'd1);
    for (int i = 0; i < 8; i++) req_q.push_back(wash_exp[i]);
  endtask

  task automatic push_run();
    for (int i = 0; i < 3; i++) rd_q.push_back(32'd2 + i);
    for (int i = 0; i < 12; i++) req_q.push_back(run_exp[i]);
    for (int i = 0; i < 8; i++) begin
      hwa_q.push_back(i);
      hwd_q.push_back(hist_exp[i]);
    end
  endtask

  task automatic drained(input string name);
    chk({name, "_rd_left"}, rd_q.size(), 0);
    chk({name, "_req_left"}, req_q.size(), 0);
    chk({name, "_hist_left"}, hwa_q.size(), 0);
  endtask

  task automatic pulse_rsv_rst();
    reservoir_en  = 1'b0;
    reservoir_rst = 1'b1;
    step(1);
    reservoir_rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, hbase;
    bit seen;

    step(3);
    chk("rst_init_busy", reservoir_init_busy, 1);
    chk("rst_busy", reservoir_busy, 1);
    chk("rst_filled", reservoir_filled, 0);
    chk("rst_node_req", node_req, 0);
    chk("rst_rd_en", sample_rd_en, 0);
    chk("rst_hist_wr", history_wr_en, 0);
    chk("rst_sample_addr", sample_addr, 0);
    chk("rst_node_data_in", node_data_in, 0);
    rst = 1'b1;
    step(2);

    // Washout
    push_wash();
    base = ack_count;
    reservoir_en = 1'b1;
    wait_for(0, 200, "washout_done");
    chk("washout_acks", ack_count - base, 8);
    chk("washout_busy", reservoir_busy, 1);
    chk("washout_filled", reservoir_filled, 0);
    step(10);
    chk("washout_idle_reads", rd_count, 2);
    if (rd_t.size() >= 1 && req_t.size() >= 5) begin
      chk("lat_fetch_to_req", req_t[0] - rd_t[0], 2);
      chk("lat_node_to_node", req_t[1] - req_t[0], 2);
      chk("lat_sample_to_sample", req_t[4] - req_t[3], 4);
    end else begin
      unexpected("latency_samples_missing", req_t.size());
    end
    drained("washout");

    // Run with history
    push_run();
    base = ack_count; rbase = rd_count; hbase = hist_count;
    reservoir_history_en = 1'b1;
    sample_cntr_rst = 1'b1;
    step(1);
    sample_cntr_rst = 1'b0;
    chk("cntr_rst_keeps_init", reservoir_init_busy, 0);
    wait_for(2, 200, "run_filled");
    chk("filled_acks", ack_count - base, 4);
    wait_for(1, 300, "run_done");
    chk("run_acks", ack_count - base, 12);
    chk("run_hist_count", hist_count - hbase, 8);
    step(10);
    sample_cntr_rst = 1'b1;
    step(1);
    sample_cntr_rst = 1'b0;
    step(10);
    chk("run_done_ignores_en", rd_count - rbase, 3);
    chk("run_done_sticky", reservoir_busy, 0);
    drained("run");

    // Stall: delayed ack over a full washout and run
    pulse_rsv_rst();
    chk("rsv_rst_init_busy", reservoir_init_busy, 1);
    chk("rsv_rst_busy", reservoir_busy, 1);
    chk("rsv_rst_filled", reservoir_filled, 0);
    ack_delay = 5;
    push_wash();
    base = ack_count;
    reservoir_en = 1'b1;
    wait_for(0, 400, "stall_washout_done");
    chk("stall_washout_acks", ack_count - base, 8);
    push_run();
    base = ack_count; hbase = hist_count;
    sample_cntr_rst = 1'b1;
    step(1);
    sample_cntr_rst = 1'b0;
    wait_for(1, 600, "stall_run_done");
    chk("stall_run_acks", ack_count - base, 12);
    chk("stall_hist_per_ack", hist_count - hbase, 8);
    drained("stall");

    // Pause after node 1, then resume without re-fetch
    pulse_rsv_rst();
    ack_delay = 3;
    push_wash();
    base = ack_count; rbase = rd_count;
    reservoir_en = 1'b1;
    cond_target = base + 1;
    wait_for(3, 100, "pause_node1_req");
    reservoir_en = 1'b0;
    step(12);
    chk("pause_acks", ack_count - base, 2);
    chk("pause_req_low", node_req, 0);
    chk("pause_reads", rd_count - rbase, 1);
    reservoir_en = 1'b1;
    wait_for(0, 300, "pause_washout_done");
    chk("pause_total_acks", ack_count - base, 8);
    chk("pause_total_reads", rd_count - rbase, 2);
    drained("pause");

    // Saturation of the most negative sample
    pulse_rsv_rst();
    ack_delay = 0;
    sat_mode  = 1'b1;
    rd_q.push_back(32'd0);
    rd_q.push_back(32'd1);
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h7FFF_FFFF);
    req_q.push_back(32'h8000_0000);
    req_q.push_back(32'h7FFF_FFFF);
    for (int i = 4; i < 8; i++) req_q.push_back(wash_exp[i]);
    reservoir_en = 1'b1;
    wait_for(0, 200, "sat_washout_done");
    sat_mode = 1'b0;
    drained("sat");

    // Abort with reservoir_rst coinciding with an ack
    pulse_rsv_rst();
    ack_delay = 2;
    rd_q.push_back(32'd0);
    req_q.push_back(32'd10);
    push_wash();
    base = ack_count;
    reservoir_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (node_ack) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_ack_seen: no ack within 50 cycles, required one");
    end
    reservoir_rst = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_req_dropped", node_req, 0);
    chk("abort_init_busy", reservoir_init_busy, 1);
    chk("abort_ack_ignored", ack_count - base, 0);
    reservoir_rst = 1'b0;
    wait_for(0, 300, "abort_washout_done");
    chk("abort_acks", ack_count - base, 8);
    drained("abort");

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
